// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver: FSM state encoding
// and the frame-length helper used by the design and its bench.
package serial_parity_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      PARITY    = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   // Start + data + parity + stop.
   function automatic int frame_len(input int data_bits);
      return data_bits + 3;
   endfunction

endpackage

// File: rtl/xor_1_bit.sv
// Three-input single-bit XOR; used as the running-parity element.
module xor_1_bit (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   assign y = a ^ b ^ c;

endmodule

// File: rtl/serial_parity_rx.sv
// LSB-first serial frame receiver (start, data, parity, stop) with
// parity and framing error reporting; advances only on bit_en strobes.
module serial_parity_rx
   import serial_parity_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int             CW       = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_BITS - 1);

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d, shreg_shift;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 acc_q, acc_d, acc_next;
   logic                 pend_good_q, pend_good_d;
   logic                 pend_bad_q, pend_bad_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;

   xor_1_bit u_parity (
      .a (acc_q),
      .b (rx),
      .c (1'b0),
      .y (acc_next)
   );

   if (DATA_BITS == 1) begin : g_shift_one
      assign shreg_shift = rx;
   end else begin : g_shift_many
      assign shreg_shift = {rx, shreg_q[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bit_en) begin
         case (state_q)
            IDLE:      if (!rx) state_d = DATA;
            DATA:      if (cnt_q == LAST_CNT) state_d = PARITY;
            PARITY:    state_d = STOP;
            STOP:      state_d = rx ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   // Results are staged for one clock after the stop sample. shreg and acc
   // cannot change on that following edge (IDLE only reloads acc_d), so the
   // commit reads them straight from the flops.
   always_comb begin
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      pend_good_d  = 1'b0;
      pend_bad_d   = 1'b0;
      data_valid_d = pend_good_q;
      frame_err_d  = pend_bad_q;
      data_out_d   = pend_good_q ? shreg_q : data_out_q;
      parity_err_d = pend_good_q ? acc_q : parity_err_q;
      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!rx) begin
                  cnt_d = '0;
                  acc_d = ODD_PARITY;
               end
            end
            DATA: begin
               shreg_d = shreg_shift;
               acc_d   = acc_next;
               cnt_d   = cnt_q + CW'(1);
            end
            PARITY: acc_d = acc_next;
            STOP: begin
               if (rx) pend_good_d = 1'b1;
               else    pend_bad_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q      <= '0;
         cnt_q        <= '0;
         acc_q        <= 1'b0;
         pend_good_q  <= 1'b0;
         pend_bad_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         pend_good_q  <= pend_good_d;
         pend_bad_q   <= pend_bad_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even- and an odd-parity receiver share one
// serial line; frame-level expectations come from a parity model per frame.
module tb_serial_parity_rx;
   import serial_parity_rx_pkg::*;

   localparam int DB = 8;
   localparam int EW = 32 + 1 + DB;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          bit_en = 1'b0;
   logic          rx     = 1'b1;
   logic [DB-1:0] dout_e, dout_o;
   logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Expected entries: {due cycle, parity_err, data}.
   logic [EW-1:0] exp_q_e[$];
   logic [EW-1:0] exp_q_o[$];
   logic [31:0]   fe_q_e[$];
   logic [31:0]   fe_q_o[$];
   logic [EW-1:0] ent_e, ent_o;

   serial_parity_rx #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
      .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
      .frame_err(fe_e), .busy(busy_e)
   );

   serial_parity_rx #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
      .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
      .frame_err(fe_o), .busy(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(100 * frame_len(DB) * 100);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Parity error iff the count of ones over data and parity bit breaks the mode.
   function automatic logic perr_model(input logic [DB-1:0] d, input logic p, input bit odd);
      int ones;
      ones = $countones(d) + int'(p);
      return odd ? (ones % 2 == 0) : (ones % 2 != 0);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic b, input int gap);
      repeat (gap) begin
         bit_en = 1'b0;
         rx     = 1'($urandom);
         @(posedge clk);
         #1;
      end
      rx     = b;
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop, input int gmax);
      logic [31:0] due;
      strobe(1'b0, $urandom_range(gmax, 0));
      for (int i = 0; i < DB; i++) strobe(d[i], $urandom_range(gmax, 0));
      strobe(p, $urandom_range(gmax, 0));
      strobe(stop, $urandom_range(gmax, 0));
      due = 32'(cyc + 1);
      if (stop) begin
         exp_q_e.push_back({due, perr_model(d, p, 1'b0), d});
         exp_q_o.push_back({due, perr_model(d, p, 1'b1), d});
      end else begin
         fe_q_e.push_back(due);
         fe_q_o.push_back(due);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dv_e) begin
            if (exp_q_e.size() == 0) check("dv_e_unexpected", 32'(dv_e), 0);
            else begin
               ent_e = exp_q_e.pop_front();
               check("dv_e_cycle", 32'(cyc), ent_e[EW-1 -: 32]);
               check("dout_e", 32'(dout_e), 32'(ent_e[DB-1:0]));
               check("perr_e", 32'(pe_e), 32'(ent_e[DB]));
            end
         end else if (exp_q_e.size() > 0 && ent_due(exp_q_e[0]) <= 32'(cyc)) begin
            check("dv_e_missing", 32'(dv_e), 1);
            void'(exp_q_e.pop_front());
         end
         if (fe_e) begin
            if (fe_q_e.size() == 0) check("fe_e_unexpected", 32'(fe_e), 0);
            else check("fe_e_cycle", 32'(cyc), fe_q_e.pop_front());
         end else if (fe_q_e.size() > 0 && fe_q_e[0] <= 32'(cyc)) begin
            check("fe_e_missing", 32'(fe_e), 1);
            void'(fe_q_e.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (dv_o) begin
            if (exp_q_o.size() == 0) check("dv_o_unexpected", 32'(dv_o), 0);
            else begin
               ent_o = exp_q_o.pop_front();
               check("dv_o_cycle", 32'(cyc), ent_o[EW-1 -: 32]);
               check("dout_o", 32'(dout_o), 32'(ent_o[DB-1:0]));
               check("perr_o", 32'(pe_o), 32'(ent_o[DB]));
            end
         end else if (exp_q_o.size() > 0 && ent_due(exp_q_o[0]) <= 32'(cyc)) begin
            check("dv_o_missing", 32'(dv_o), 1);
            void'(exp_q_o.pop_front());
         end
         if (fe_o) begin
            if (fe_q_o.size() == 0) check("fe_o_unexpected", 32'(fe_o), 0);
            else check("fe_o_cycle", 32'(cyc), fe_q_o.pop_front());
         end else if (fe_q_o.size() > 0 && fe_q_o[0] <= 32'(cyc)) begin
            check("fe_o_missing", 32'(fe_o), 1);
            void'(fe_q_o.pop_front());
         end
      end
   end

   function automatic logic [31:0] ent_due(input logic [EW-1:0] ent);
      return ent[EW-1 -: 32];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_dout_e"}, 32'(dout_e), 0);
      check({tag, "_dout_o"}, 32'(dout_o), 0);
      check({tag, "_dv"}, 32'({dv_e, dv_o}), 0);
      check({tag, "_pe"}, 32'({pe_e, pe_o}), 0);
      check({tag, "_fe"}, 32'({fe_e, fe_o}), 0);
      check({tag, "_busy"}, 32'({busy_e, busy_o}), 0);
   endtask

   initial begin
      logic [DB-1:0] d;
      logic          p, stop;

      idle(3);
      check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      idle(1);

      // Good frame, then a parity error that the odd receiver accepts.
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      idle(3);
      check("busy_after_a5", 32'({busy_e, busy_o}), 0);
      send_frame(8'h07, 1'b0, 1'b1, 0);
      idle(3);
      check("pe_e_hold_07", 32'(pe_e), 1);
      check("pe_o_hold_07", 32'(pe_o), 0);

      // Bad stop bit followed by a held-low break line.
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         strobe(1'b0, 0);
         check("break_busy_e", 32'(busy_e), 1);
      end
      check("dout_e_kept_after_ferr", 32'(dout_e), 32'h07);
      check("pe_e_kept_after_ferr", 32'(pe_e), 1);
      strobe(1'b1, 0);
      check("busy_after_break", 32'({busy_e, busy_o}), 0);

      // Irregular strobe spacing.
      send_frame(8'h81, 1'b0, 1'b1, 4);
      idle(3);

      // Asynchronous reset after four data bits.
      strobe(1'b0, 0);
      for (int i = 0; i < 4; i++) strobe(1'b1, 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      idle(2);
      @(negedge clk) rst_n = 1'b1;
      idle(1);
      send_frame(8'h12, 1'b0, 1'b1, 0);
      idle(3);

      // Back-to-back frames.
      send_frame(8'h55, 1'b0, 1'b1, 0);
      send_frame(8'hAA, 1'b0, 1'b1, 0);
      idle(3);

      for (int n = 0; n < 60; n++) begin
         d    = DB'($urandom);
         p    = (^d) ^ ($urandom_range(3, 0) == 0);
         stop = ($urandom_range(5, 0) != 0);
         send_frame(d, p, stop, 3);
         if (!stop) begin
            repeat ($urandom_range(3, 0)) strobe(1'b0, $urandom_range(2, 0));
            strobe(1'b1, $urandom_range(2, 0));
         end
         repeat ($urandom_range(2, 0)) strobe(1'b1, $urandom_range(2, 0));
      end

      idle(5);
      check("exp_q_e_drained", exp_q_e.size(), 0);
      check("exp_q_o_drained", exp_q_o.size(), 0);
      check("fe_q_e_drained", fe_q_e.size(), 0);
      check("fe_q_o_drained", fe_q_o.size(), 0);
      check("busy_final", 32'({busy_e, busy_o}), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
